umi_loc_mem: RTL
================

// Module: umi_loc_mem
// PURPOSE
//  Local memory target for the loc_* side of the UMI endpoint.
//  Services single-beat reads and writes with LSB-aligned data and byte-granular writes.
//  Returns read data one cycle after the read strobe.
//  Back-pressures through loc_ready using a programmable wait-state counter.
// PARAMETERS
//  AW     64   address width
//  DW     256  data width; DW/8 bytes per word; power of 2, >=16
//  DEPTH  64   words of storage; power of 2
//  WAIT   0    stall cycles inserted after each accepted access (0..255)
// PORTS
//  clk         in   1     clock; all state on posedge
//  reset       in   1     async, active-high reset
//  loc_addr    in   AW    byte address
//  loc_write   in   1     write strobe, already qualified by loc_ready upstream
//  loc_read    in   1     read strobe, already qualified by loc_ready upstream
//  loc_opcode  in   8     ignored (atomics unsupported)
//  loc_size    in   3     bytes per element = 1<<loc_size
//  loc_len     in   8     elements minus one
//  loc_wrdata  in   DW    write data, LSB-aligned
//  loc_rddata  out  DW    read data, LSB-aligned
//  loc_ready   out  1     block can accept an access this cycle
//  loc_err     out  1     one-cycle error pulse
// BEHAVIOUR
//  Interface: one clock, clk; asynchronous active-high reset, reset.
//  Address fields: OB = log2(DW/8), IB = log2(DEPTH).
//  - off = loc_addr[OB-1:0]; idx = loc_addr[OB+IB-1:OB].
//  - oor = |loc_addr[AW-1:OB+IB] (out of range).
//  Accept: acc = (loc_read|loc_write) & loc_ready. Strobes while loc_ready=0 are ignored.
//  Byte count: nb = (loc_len+1) << loc_size, computed in 17 bits (no overflow).
//  Write: bytes k = 0..nb-1 with off+k < DW/8 are written.
//  - Each written byte takes loc_wrdata byte k into word idx, byte off+k.
//  - Bytes past the word end are dropped and loc_err pulses.
//  - Other bytes in the word are unchanged.
//  Read: loc_rddata <= mem[idx] >> (8*off), zero-filled above.
//  - Registered: valid the cycle after the accepted loc_read.
//  - Held until the next accepted read.
//  - nb overrunning the word end also pulses loc_err; data is still returned.
//  oor access: no write; read returns 0; loc_err pulses.
//  loc_read & loc_write together: write performed, read ignored, loc_rddata held, loc_err pulses.
//  loc_err: registered; asserts the cycle after the offending accept, for one cycle.
//  Ready FSM, 8-bit counter cnt:
//  - IDLE: loc_ready=1. On acc with WAIT>0, go to BUSY with cnt=WAIT.
//  - BUSY: loc_ready=0; cnt decrements each cycle; cnt==1 -> IDLE.
//  - WAIT=0: FSM stays in IDLE and loc_ready is constantly 1.
//  - Back-to-back accepts are allowed every WAIT+1 cycles.
//  Reset values: state=IDLE, cnt=0, loc_ready=1, loc_rddata=0, loc_err=0.
//  - Memory contents are not reset.
//  - Strobes are ignored while reset is high.
//  - reset asserted mid-BUSY returns to IDLE immediately; no partial write occurs.
// TESTING (DW=256, DEPTH=64, AW=64)
//  1. Write addr 0x40, size=2, len=0, data 0xDEADBEEF; then read 0x40 ->
//     next cycle loc_rddata = 0x...00DEADBEEF, loc_err=0.
//  2. Write addr 0x5E, size=0, len=3, data 0x44332211 ->
//     only bytes 0x5E,0x5F written (0x11,0x22); loc_err=1 for one cycle;
//     read 0x40 shows 0x2211 in bits [255:240].
//  3. Read addr 0x800 (oor) -> loc_rddata=0, loc_err=1, memory unchanged.
//  4. WAIT=3, reads every cycle -> accepts at t0, t4, t8;
//     loc_ready low t1..t3; loc_rddata updates t1, t5, t9.
//  5. WAIT=3, reset pulsed at t2 of BUSY -> loc_ready=1 from reset assertion;
//     loc_rddata=0; next access accepted.
//  6. Simultaneous read+write at 0x20 with data 0xAA ->
//     mem byte 0x20 = 0xAA, loc_rddata unchanged, loc_err=1.

Source files
------------

// File: rtl/umi_loc_mem.sv
// umi_loc_mem: local UMI memory target with byte-granular writes, registered reads and wait-state back-pressure
module umi_loc_mem #(
    parameter int AW    = 64,
    parameter int DW    = 256,
    parameter int DEPTH = 64,
    parameter int WAIT  = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] loc_addr,
    input  logic          loc_write,
    input  logic          loc_read,
    input  logic [7:0]    loc_opcode,
    input  logic [2:0]    loc_size,
    input  logic [7:0]    loc_len,
    input  logic [DW-1:0] loc_wrdata,
    output logic [DW-1:0] loc_rddata,
    output logic          loc_ready,
    output logic          loc_err
);
    localparam int NB = DW / 8;
    localparam int OB = $clog2(NB);
    localparam int IB = $clog2(DEPTH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_nxt;
    logic [7:0]    cnt, cnt_nxt;
    logic [DW-1:0] mem [DEPTH];
    logic [OB-1:0] off;
    logic [IB-1:0] idx;
    logic          oor, acc, wen, ren, ovr;
    logic [16:0]   nb;
    logic [17:0]   endb;
    logic [DW-1:0] bmask, wsh;
    logic          unused_opcode;

    assign unused_opcode = ^loc_opcode;
    assign off  = loc_addr[OB-1:0];
    assign idx  = loc_addr[OB+IB-1:OB];
    assign oor  = |loc_addr[AW-1:OB+IB];
    assign nb   = (17'(loc_len) + 17'd1) << loc_size;
    assign endb = 18'(off) + 18'(nb);
    assign ovr  = endb > 18'(NB);
    assign acc  = (loc_read | loc_write) & loc_ready & ~reset;
    assign wen  = acc & loc_write & ~oor;
    assign ren  = acc & loc_read & ~loc_write;
    assign wsh  = loc_wrdata << {off, 3'b000};
    assign loc_ready = (state == IDLE);

    // byte lanes covered by the access: [off, off+nb) clipped to the word
    always_comb begin
        bmask = '0;
        for (int j = 0; j < NB; j++)
            bmask[8*j +: 8] = (18'(j) >= 18'(off)) && (18'(j) < endb) ? 8'hff : 8'h00;
    end

    // storage update, merging new bytes into the addressed word
    always_ff @(posedge clk)
        if (wen) mem[idx] <= (mem[idx] & ~bmask) | (wsh & bmask);

    // registered read data and one-cycle error pulse
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            loc_rddata <= '0;
            loc_err    <= 1'b0;
        end else begin
            loc_err <= acc & (oor | (loc_read & loc_write) | ovr);
            if (ren) loc_rddata <= oor ? '0 : mem[idx] >> {off, 3'b000};
        end

    // ready FSM state register
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end

    // wait-state sequencing: WAIT stall cycles after every accept
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == IDLE) begin
            if (acc && WAIT > 0) begin
                state_nxt = BUSY;
                cnt_nxt   = 8'(WAIT);
            end
        end else begin
            cnt_nxt = cnt - 8'd1;
            if (cnt == 8'd1) state_nxt = IDLE;
        end
    end
endmodule
